// File: rtl/muldiv.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// Latency: MTHI/MTLO write at the accept edge; MULT/DIV-class ops take 32 cycles.
// Backpressure: Busy holds for the whole iteration. Start is dropped, not queued, while Busy=1.
//
// Ports:
//   Clk, Reset   - clock, asynchronous active-high reset
//   Start, Op    - request valid and opcode (sampled only while Busy=0)
//   A, B         - operands (rs, rt), latched at accept
//   Flush        - squash the operation in progress / block an accept
//   Out          - HI for MFHI, LO for MFLO, otherwise 0 (combinational)
//   Busy         - iterative operation in progress
//   Done         - one-cycle pulse after an iterative op updates HI/LO
//   DivZero      - pulses with Done when the finished divide had B=0
//
// Build option: define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (Op 9-12).
// Without it those codes are treated as NOP.
module muldiv (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [3:0]  Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Flush,
   output logic [31:0] Out,
   output logic        Busy,
   output logic        Done,
   output logic        DivZero
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MULDIV_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [31:0] hi, lo;

   // Shared iteration register.
   //   MUL: [63:32] partial sum, [31:0] multiplier bits still to consume
   //   DIV: [63:32] partial remainder, [31:0] dividend bits / quotient bits
   logic [63:0] acc;
   logic [31:0] opnd;        // multiplicand or divisor magnitude
   logic        neg_q;       // negate product / quotient at the end
   logic        neg_r;       // negate remainder (dividend was negative)
   logic        dz;          // divisor was zero
   logic        done_r;
   logic        dz_r;
`ifdef MULDIV_MADD_EN
   logic        acc_add;     // MADD/MADDU: {HI,LO} += product
   logic        acc_sub;     // MSUB/MSUBU: {HI,LO} -= product
   logic        is_add, is_sub;
`endif

   // Request decode
   logic        accept;
   logic        is_mul_op, is_div_op, is_signed;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;

   always_comb begin
      is_mul_op = (Op == OP_MULT) || (Op == OP_MULTU);
      is_div_op = (Op == OP_DIV)  || (Op == OP_DIVU);
      is_signed = (Op == OP_MULT) || (Op == OP_DIV);
`ifdef MULDIV_MADD_EN
      is_add    = (Op == OP_MADD) || (Op == OP_MADDU);
      is_sub    = (Op == OP_MSUB) || (Op == OP_MSUBU);
      is_mul_op = is_mul_op || is_add || is_sub;
      is_signed = is_signed || (Op == OP_MADD) || (Op == OP_MSUB);
`endif
      a_neg = is_signed & A[31];
      b_neg = is_signed & B[31];
      a_mag = a_neg ? (~A + 32'd1) : A;
      b_mag = b_neg ? (~B + 32'd1) : B;
   end

   assign Busy   = (state != IDLE);
   assign accept = Start && !Busy && !Flush;

   // One iteration step of each engine
   logic [32:0] mul_sum;
   logic [63:0] mul_step;
   logic [32:0] rem_shift;
   logic        div_ge;
   logic [31:0] rem_diff, rem_new;
   logic [63:0] div_step;

   always_comb begin
      // Shift-add: add the multiplicand when the current multiplier bit is set,
      // then shift the whole register right, carry included.
      mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
      mul_step = {mul_sum, acc[31:1]};

      // Restoring divide: bring in the next dividend bit and subtract if it fits.
      // When it fits the true difference is below 2^32, so a 32-bit subtract suffices.
      rem_shift = {acc[63:32], acc[31]};
      div_ge    = (rem_shift >= {1'b0, opnd});
      rem_diff  = rem_shift[31:0] - opnd;
      rem_new   = div_ge ? rem_diff : rem_shift[31:0];
      div_step  = {rem_new, acc[30:0], div_ge};
   end

   // Final results, consumed on the last iteration edge
   logic [63:0] mul_res, mul_final, div_final;
   logic [31:0] quo_s, rem_s;

   always_comb begin
      mul_res = neg_q ? (~mul_step + 64'd1) : mul_step;
`ifdef MULDIV_MADD_EN
      if (acc_add)
         mul_final = {hi, lo} + mul_res;
      else if (acc_sub)
         mul_final = {hi, lo} - mul_res;
      else
         mul_final = mul_res;
`else
      mul_final = mul_res;
`endif
      // Divisor zero naturally yields quotient all-ones and remainder = |A|;
      // neg_q is forced low for that case so only the remainder gets its sign back (HI = A).
      // 0x80000000 / -1 gives magnitude 0x80000000, whose negation is itself.
      quo_s     = neg_q ? (~div_step[31:0] + 32'd1)  : div_step[31:0];
      rem_s     = neg_r ? (~div_step[63:32] + 32'd1) : div_step[63:32];
      div_final = {rem_s, quo_s};
   end

   // FSM
   logic load_mul, load_div, wr_hi, wr_lo, finish;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_mul  = 1'b0;
      load_div  = 1'b0;
      wr_hi     = 1'b0;
      wr_lo     = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_mul_op) begin
                  state_nxt = MUL;
                  load_mul  = 1'b1;
               end else if (is_div_op) begin
                  state_nxt = DIV;
                  load_div  = 1'b1;
               end
               wr_hi = (Op == OP_MTHI);
               wr_lo = (Op == OP_MTLO);
            end
         end
         MUL, DIV: begin
            if (Flush) begin
               state_nxt = IDLE;
            end else if (cnt == 5'd31) begin
               state_nxt = IDLE;
               finish    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt    <= 5'd0;
         hi     <= 32'd0;
         lo     <= 32'd0;
         acc    <= 64'd0;
         opnd   <= 32'd0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         done_r <= 1'b0;
         dz_r   <= 1'b0;
`ifdef MULDIV_MADD_EN
         acc_add <= 1'b0;
         acc_sub <= 1'b0;
`endif
      end else begin
         done_r <= finish;
         dz_r   <= finish & dz;

         if (load_mul) begin
            acc  <= {32'd0, b_mag};
            opnd <= a_mag;
         end else if (load_div) begin
            acc  <= {32'd0, a_mag};
            opnd <= b_mag;
         end else if (Busy) begin
            acc  <= (state == MUL) ? mul_step : div_step;
         end

         if (load_mul || load_div || Flush)
            cnt <= 5'd0;
         else if (Busy)
            cnt <= cnt + 5'd1;

         if (load_mul || load_div) begin
            neg_q <= (a_neg ^ b_neg) & (B != 32'd0);
            neg_r <= a_neg;
            dz    <= is_div_op & (B == 32'd0);
`ifdef MULDIV_MADD_EN
            acc_add <= is_add;
            acc_sub <= is_sub;
`endif
         end

         if (finish) begin
            {hi, lo} <= (state == MUL) ? mul_final : div_final;
         end else begin
            if (wr_hi) hi <= A;
            if (wr_lo) lo <= A;
         end
      end
   end

   assign Done    = done_r;
   assign DivZero = dz_r;

   always_comb begin
      Out = 32'd0;
      if (Op == OP_MFHI)
         Out = hi;
      else if (Op == OP_MFLO)
         Out = lo;
   end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed known-answer sequences plus random traffic,
// all compared every cycle against a transaction-level model of HI/LO and the handshake.
module tb_muldiv;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [3:0]  Op = 4'd0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic        Flush = 1'b0;
   logic [31:0] Out;
   logic        Busy, Done, DivZero;

   muldiv dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .Flush(Flush), .Out(Out), .Busy(Busy), .Done(Done), .DivZero(DivZero)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit iter_op(input logic [3:0] op);
`ifdef MULDIV_MADD_EN
      return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12);
`else
      return (op >= 4'd1 && op <= 4'd4);
`endif
   endfunction

   function automatic logic [63:0] expect_res(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] h,
                                              input logic [31:0] l);
      logic [63:0] ps, pu;
      logic signed [31:0] sa, sb, q, r;
      ps = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      pu = {32'd0, a} * {32'd0, b};
      sa = a;
      sb = b;
      case (op)
         4'd1: return ps;
         4'd2: return pu;
         4'd3: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
         4'd4: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
         4'd9:  return {h, l} + ps;
         4'd10: return {h, l} + pu;
         4'd11: return {h, l} - ps;
         4'd12: return {h, l} - pu;
         default: return {h, l};
      endcase
   endfunction

   bit          m_valid = 0;
   logic [31:0] m_hi, m_lo, m_a, m_b;
   logic [3:0]  m_op;
   bit          m_busy, m_done, m_dz;
   int          m_left;

   always @(posedge Clk or posedge Reset) begin
      logic [63:0] res;
      if (Reset) begin
         m_valid = 1;
         m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_dz = 0; m_left = 0;
      end else begin
         m_done = 0;
         m_dz   = 0;
         if (m_busy) begin
            if (Flush) begin
               m_busy = 0;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  res    = expect_res(m_op, m_a, m_b, m_hi, m_lo);
                  m_hi   = res[63:32];
                  m_lo   = res[31:0];
                  m_busy = 0;
                  m_done = 1;
                  m_dz   = (m_op == 4'd3 || m_op == 4'd4) && (m_b == 32'd0);
               end
            end
         end else if (Start && !Flush) begin
            if (Op == 4'd5) m_hi = A;
            else if (Op == 4'd6) m_lo = A;
            else if (iter_op(Op)) begin
               m_op = Op; m_a = A; m_b = B;
               m_busy = 1;
               m_left = 32;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge Clk) begin
      logic [31:0] exp_out;
      if (m_valid && !Reset) begin
         exp_out = (Op == 4'd7) ? m_hi : (Op == 4'd8) ? m_lo : 32'd0;
         chk("busy", Busy, m_busy);
         chk("done", Done, m_done);
         chk("divzero", DivZero, m_dz);
         chk("out", Out, exp_out);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      @(posedge Clk);
      #2;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      Op = op; A = a; B = b; Start = 1'b1;
      cycle();
      Start = 1'b0; Op = 4'd0;
      A = $urandom; B = $urandom;   // must not disturb the latched operands
   endtask

   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output bit dz_seen);
      int  nbusy;
      bit  got;
      nbusy = 0; got = 0; dz_seen = 0;
      issue(op, a, b);
      for (int i = 0; i < 40; i++) begin
         if (Done) begin
            got = 1;
            dz_seen = DivZero;
            break;
         end
         if (Busy) nbusy++;
         cycle();
      end
      chk({name, "_done_seen"}, got, 1);
      chk({name, "_busy_cycles"}, nbusy, 32);
   endtask

   task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
      Op = 4'd7; #1 chk({name, "_hi"}, Out, eh);
      Op = 4'd8; #1 chk({name, "_lo"}, Out, el);
      Op = 4'd0;
   endtask

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      bit dzs;
      bit seen;

      // Reset state
      cycle(); cycle();
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_divzero", DivZero, 0);
      check_hilo("rst", 32'd0, 32'd0);
      Reset = 1'b0;
      cycle();

      // MULT / MULTU, second issued in the Done cycle of the first
      run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, dzs);
      check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, dzs);
      check_hilo("multu", 32'h00000002, 32'hFFFFFFFA);

      // Divides
      run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, dzs);
      check_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
      chk("div_dz", dzs, 0);
      run_op("divu0", 4'd4, 32'd7, 32'd0, dzs);
      check_hilo("divu0", 32'd7, 32'hFFFFFFFF);
      chk("divu0_dz", dzs, 1);
      run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, dzs);
      check_hilo("divovf", 32'd0, 32'h80000000);
      chk("divovf_dz", dzs, 0);
      run_op("divneg0", 4'd3, 32'hFFFFFF00, 32'd0, dzs);
      check_hilo("divneg0", 32'hFFFFFF00, 32'hFFFFFFFF);
      chk("divneg0_dz", dzs, 1);

      // MTHI / MTLO never raise Busy
      issue(4'd5, 32'h12345678, 32'd0);
      chk("mthi_busy", Busy, 0);
      issue(4'd6, 32'h9ABCDEF0, 32'd0);
      chk("mtlo_busy", Busy, 0);
      check_hilo("mthilo", 32'h12345678, 32'h9ABCDEF0);

      // Flush mid-operation; Start during Busy is ignored
      issue(4'd1, 32'd5, 32'd5);
      for (int i = 0; i < 8; i++) begin
         Start = 1'b1; Op = 4'd6; A = 32'hDEADBEEF;
         cycle();
      end
      Flush = 1'b1;
      cycle();
      Flush = 1'b0; Start = 1'b0; Op = 4'd0;
      chk("flush_busy", Busy, 0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         seen |= Done;
         cycle();
      end
      chk("flush_nodone", seen, 0);
      check_hilo("flush", 32'h12345678, 32'h9ABCDEF0);

      // Flush together with Start: no accept
      Flush = 1'b1;
      issue(4'd5, 32'h55555555, 32'd0);
      Flush = 1'b0;
      chk("flush_start_busy", Busy, 0);
      check_hilo("flush_start", 32'h12345678, 32'h9ABCDEF0);

      // Asynchronous reset in the middle of a DIV
      issue(4'd3, 32'd1000, 32'd7);
      for (int i = 0; i < 19; i++) cycle();
      Op = 4'd7;
      #1 Reset = 1'b1;
      #1 chk("arst_busy", Busy, 0);
      chk("arst_hi", Out, 32'd0);
      Op = 4'd8;
      #1 chk("arst_lo", Out, 32'd0);
      Op = 4'd0;
      cycle();
      Reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         seen |= Done;
         cycle();
      end
      chk("arst_nodone", seen, 0);

      // Accumulate ops
      issue(4'd6, 32'd10, 32'd0);
`ifdef MULDIV_MADD_EN
      run_op("maddu", 4'd10, 32'd3, 32'd4, dzs);
      check_hilo("maddu", 32'd0, 32'd22);
      run_op("msub", 4'd11, 32'hFFFFFFFF, 32'd30, dzs);
      check_hilo("msub", 32'd0, 32'd52);
`else
      issue(4'd10, 32'd3, 32'd4);
      chk("maddu_off_busy", Busy, 0);
      cycle(); cycle();
      check_hilo("maddu_off", 32'd0, 32'd10);
`endif

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         Start = ($urandom_range(0, 2) == 0);
         Op    = $urandom_range(0, 15);
         A     = pick32();
         B     = pick32();
         Flush = ($urandom_range(0, 59) == 0);
         cycle();
      end
      Start = 1'b0; Flush = 1'b0; Op = 4'd0;
      for (int i = 0; i < 40; i++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning); clock and reset come first.
REQ-002 Clk  in  1  single clock; all state changes on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 Start  in  1  request valid; sampled only when Busy=0.
REQ-005 Op  in  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; 13-15 NOP.
REQ-006 A  in  32  operand rs: multiplicand, dividend, or MTHI/MTLO data.
REQ-007 B  in  32  operand rt: multiplier or divisor.
REQ-008 Flush  in  1  abort the operation in progress (pipeline squash).
REQ-009 Out  out  32  combinational: HI when Op=MFHI, LO when Op=MFLO, else 0.
REQ-010 Busy  out  1  iterative operation in progress; execute stage stalls on it.
REQ-011 Done  out  1  one-cycle pulse following the HI/LO update of an iterative op.
REQ-012 DivZero  out  1  pulses with Done when the completed DIV/DIVU had B=0.

Function
REQ-013 States SHALL be IDLE, MUL, DIV; a 5-bit iteration counter SHALL count 0..31.
REQ-014 Accept at edge k when Start=1, Busy=0, Flush=0.
REQ-015 On accept, MULT/MULTU/MADD*/MSUB* go to MUL; DIV/DIVU go to DIV; Busy=1 from after edge k.
REQ-016 Iterations SHALL occur at edges k+1..k+32; HI/LO are written at edge k+32.
REQ-017 After edge k+32 the state returns to IDLE, Busy=0, and Done=1 for exactly one cycle; Busy is high for exactly 32 cycles.
REQ-018 A new accept is allowed in the cycle Done=1 (back-to-back, no bubble).
REQ-019 MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product of A and B.
REQ-020 DIV/DIVU: LO = quotient, HI = remainder.
REQ-021 Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0, and no flag.
REQ-023 Divide by zero SHALL still take 32 cycles and give LO=0xFFFFFFFF, HI=A, DivZero=1 with Done.
REQ-024 MTHI/MTLO on accept SHALL write A into HI/LO at edge k with no Busy and no Done.
REQ-025 MFHI, MFLO, NOP, and codes 13-15 SHALL change no state.
REQ-026 Out SHALL reflect the registered HI/LO values; reads during Busy return the pre-operation values.
REQ-027 Operands SHALL be latched at accept; A and B changes during Busy SHALL be ignored.
REQ-028 Start while Busy=1 SHALL be ignored and not queued.
REQ-029 Flush while Busy SHALL return the block to IDLE at the next edge with Busy=0, no Done, and HI/LO unchanged.
REQ-030 Flush on the same cycle as Start SHALL win: no accept.
REQ-031 Flush on the completion cycle (edge k+32) SHALL suppress the HI/LO write and Done.

Reset
REQ-032 While Reset=1: HI=0, LO=0, state=IDLE, counter=0, Busy=0, Done=0, DivZero=0, regardless of Clk.
REQ-033 Reset mid-operation SHALL abandon the operation; no Done SHALL follow.

Configuration
REQ-034 Macro MULDIV_MADD_EN defined: MADD/MADDU SHALL add and MSUB/MSUBU SHALL subtract the signed/unsigned product to/from {HI,LO}, modulo 2^64, at the completion edge, with MUL timing.
REQ-035 Macro MULDIV_MADD_EN undefined: Op 9-12 SHALL behave as NOP (no accept, no Busy), and no accumulate logic is synthesized.

Verification
REQ-036 MULT A=0xFFFFFFFE (-2), B=3 -> Busy 32 cycles, Done, HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=2, LO=0xFFFFFFFA.
REQ-037 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7, DivZero=1 with Done.
REQ-038 MTHI 0x12345678, then MTLO 0x9ABCDEF0, then MFHI/MFLO -> Out=0x12345678 then 0x9ABCDEF0, Busy never asserted.
REQ-039 MULT 5x5, Flush at cycle 10 -> Busy low next cycle, no Done, HI/LO keep prior values; Start asserted mid-Busy ignored.
REQ-040 Reset asserted asynchronously at cycle 20 of DIV -> Busy, HI, and LO go to 0 immediately; no Done.
REQ-041 With MULDIV_MADD_EN, MTLO 10, then MADDU 3x4 -> LO=22, HI=0; without MULDIV_MADD_EN -> no Busy, LO=10.
